// File: rtl/fetch_pc_unit.sv
// Fetch-PC generator: one I-cache request in flight, redirect capture, stale-response drop.
// Optional FETCH_PC_ADEL_EN: flag misaligned fetch targets on fetch_adel and stall requests.
module fetch_pc_unit #(
    parameter int          FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
    localparam int         CW          = $clog2(FETCH_WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_pc_en,
    input  logic          i_fifo_full,
    input  logic          i_branch_taken,
    input  logic [31:0]   i_branch_address,
    input  logic          i_exception_taken,
    input  logic [31:0]   i_exception_address,
    output logic          o_req_valid,
    output logic [31:0]   o_req_addr,
    input  logic          i_req_ready,
    input  logic          i_resp_valid,
    input  logic [CW-1:0] i_resp_count,
    output logic          o_resp_keep,
    output logic [31:0]   o_resp_pc,
    output logic [31:0]   o_pc_address,
    output logic          o_fetch_adel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FLUSH
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic        r_req_valid;
    logic [31:0] r_req_addr;
    logic [31:0] r_pend_addr;

    logic        w_redir;
    logic [31:0] w_tgt;
    logic        w_pc_load;
    logic        w_pc_step;
    logic [31:0] w_pc_d;
    logic        w_pend_load;
    logic [31:0] w_pend_d;
    logic [31:0] w_pc_inc;
    logic [31:0] w_req_base;
    logic        w_adel;

    // exception always outranks a same-cycle branch
    assign w_redir  = i_branch_taken | i_exception_taken;
    assign w_tgt    = i_exception_taken ? i_exception_address : i_branch_address;
    assign w_pc_inc = r_pc + {{(30-CW){1'b0}}, i_resp_count, 2'b00};

`ifdef FETCH_PC_ADEL_EN
    logic r_adel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adel <= 1'b0;
        end else if (w_pc_load) begin
            r_adel <= |w_pc_d[1:0];
        end
    end

    assign w_adel     = r_adel;
    assign w_req_base = r_pc;
`else
    assign w_adel     = 1'b0;
    assign w_req_base = {r_pc[31:2], 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_redir && i_pc_en && !i_fifo_full && !w_adel) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (w_redir) begin
                    w_next = i_req_ready ? S_FLUSH : S_IDLE;
                end else if (i_req_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_resp_valid) begin
                    w_next = S_IDLE;
                end else if (w_redir) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (i_resp_valid) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pc_load   = 1'b0;
        w_pc_step   = 1'b0;
        w_pc_d      = r_pc;
        w_pend_load = 1'b0;
        w_pend_d    = w_tgt;
        unique case (r_state)
            S_IDLE: begin
                if (w_redir) begin
                    w_pc_load = 1'b1;
                    w_pc_d    = w_tgt;
                end
            end
            S_REQ: begin
                if (w_redir && i_req_ready) begin
                    w_pend_load = 1'b1;
                end else if (w_redir) begin
                    w_pc_load = 1'b1;
                    w_pc_d    = w_tgt;
                end
            end
            S_WAIT: begin
                if (i_resp_valid && w_redir) begin
                    w_pc_load = 1'b1;
                    w_pc_d    = w_tgt;
                end else if (i_resp_valid) begin
                    w_pc_step = 1'b1;
                    w_pc_d    = w_pc_inc;
                end else if (w_redir) begin
                    w_pend_load = 1'b1;
                end
            end
            S_FLUSH: begin
                // a pending target yields only to a newer exception
                if (i_resp_valid) begin
                    w_pc_load = 1'b1;
                    w_pc_d    = i_exception_taken ? i_exception_address : r_pend_addr;
                end else if (i_exception_taken) begin
                    w_pend_load = 1'b1;
                    w_pend_d    = i_exception_address;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_req_valid <= 1'b0;
            r_req_addr  <= RESET_PC;
            r_pend_addr <= 32'h0;
        end else begin
            r_req_valid <= (w_next == S_REQ);
            if (r_state == S_IDLE && w_next == S_REQ) begin
                r_req_addr <= w_req_base;
            end
            if (w_pc_load || w_pc_step) begin
                r_pc <= w_pc_d;
            end
            if (w_pend_load) begin
                r_pend_addr <= w_pend_d;
            end
        end
    end

    always_comb begin
        o_resp_keep = (r_state == S_WAIT) && i_resp_valid && !w_redir;
        o_resp_pc   = r_pc;
    end

    assign o_req_valid  = r_req_valid;
    assign o_req_addr   = r_req_addr;
    assign o_pc_address = r_pc;
    assign o_fetch_adel = w_adel;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetch PC.
module tb_fetch_pc_unit;

    localparam int          FW  = 2;
    localparam int          CW  = $clog2(FW + 1);
    localparam logic [31:0] RPC = 32'hbfc0_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pc_en = 1'b0;
    logic          fifo_full = 1'b0;
    logic          br = 1'b0;
    logic [31:0]   ba = 32'h0;
    logic          ex = 1'b0;
    logic [31:0]   ea = 32'h0;
    logic          ready = 1'b0;
    logic          rv = 1'b0;
    logic [CW-1:0] rc = '0;

    logic          o_req_valid;
    logic [31:0]   o_req_addr;
    logic          o_resp_keep;
    logic [31:0]   o_resp_pc;
    logic [31:0]   o_pc_address;
    logic          o_fetch_adel;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_pc = RPC;
    logic [31:0] m_raddr = RPC;
    logic [31:0] m_pend = 32'h0;
    bit          m_req = 0;
    bit          m_infl = 0;
    bit          m_live = 0;
    bit          m_adel = 0;

    fetch_pc_unit #(.FETCH_WIDTH(FW), .RESET_PC(RPC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_pc_en             (pc_en),
        .i_fifo_full         (fifo_full),
        .i_branch_taken      (br),
        .i_branch_address    (ba),
        .i_exception_taken   (ex),
        .i_exception_address (ea),
        .o_req_valid         (o_req_valid),
        .o_req_addr          (o_req_addr),
        .i_req_ready         (ready),
        .i_resp_valid        (rv),
        .i_resp_count        (rc),
        .o_resp_keep         (o_resp_keep),
        .o_resp_pc           (o_resp_pc),
        .o_pc_address        (o_pc_address),
        .o_fetch_adel        (o_fetch_adel)
    );

    always #5 clk = ~clk;

    task automatic jump(input logic [31:0] t);
        m_pc = t;
`ifdef FETCH_PC_ADEL_EN
        m_adel = (t[1:0] != 2'b00);
`else
        m_adel = 0;
`endif
    endtask

    // advance the model by one cycle using the current inputs, then clock
    task automatic tick();
        logic        redir;
        logic [31:0] tgt;
        redir = br | ex;
        tgt   = ex ? ea : ba;
        if (rst) begin
            m_pc = RPC; m_req = 0; m_infl = 0; m_live = 0; m_adel = 0;
        end else if (m_req) begin
            if (redir && ready) begin
                m_req = 0; m_infl = 1; m_live = 0; m_pend = tgt;
            end else if (redir) begin
                m_req = 0; jump(tgt);
            end else if (ready) begin
                m_req = 0; m_infl = 1; m_live = 1;
            end
        end else if (m_infl) begin
            if (rv) begin
                m_infl = 0;
                if (!m_live) jump(ex ? ea : m_pend);
                else if (redir) jump(tgt);
                else m_pc = m_pc + 32'(rc) * 4;
            end else if (redir) begin
                if (m_live) begin
                    m_live = 0; m_pend = tgt;
                end else if (ex) begin
                    m_pend = ea;
                end
            end
        end else begin
            if (redir) begin
                jump(tgt);
            end else if (pc_en && !fifo_full && !m_adel) begin
                m_req = 1;
`ifdef FETCH_PC_ADEL_EN
                m_raddr = m_pc;
`else
                m_raddr = m_pc & 32'hffff_fffc;
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_req_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic go_idle();
        pc_en = 0; br = 0; ex = 0; rc = '0;
        for (int i = 0; i < 10; i++) begin
            if (!m_req && !m_infl) break;
            ready = 1; rv = m_infl;
            tick();
        end
        ready = 0; rv = 0;
    endtask

    task automatic test_reset();
        rst = 1; pc_en = 0;
        tick();
        tick();
        rst = 0;
        #1;
        n_total++;
        if (o_pc_address !== RPC) $display("FAIL reset_pc: got %h want %h", o_pc_address, RPC);
        else n_pass++;
        n_total++;
        if (o_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", o_req_valid);
        else n_pass++;
        n_total++;
        if (o_fetch_adel !== 1'b0) $display("FAIL reset_adel: got %b want 0", o_fetch_adel);
        else n_pass++;
    endtask

    task automatic test_sequential();
        bit          ok;
        logic [31:0] exp;
        pc_en = 1;
        for (int k = 0; k < 3; k++) begin
            exp = RPC + 32'(8 * k);
            wait_req(ok);
            n_total++;
            if (!ok) $display("FAIL seq_timeout: got no request want request %0d", k);
            else n_pass++;
            n_total++;
            if (o_req_addr !== exp) $display("FAIL seq_req_addr: got %h want %h", o_req_addr, exp);
            else n_pass++;
            ready = 1;
            tick();
            ready = 0; rv = 1; rc = 2'd2;
            #1;
            n_total++;
            if (o_resp_keep !== 1'b1 || o_resp_pc !== exp)
                $display("FAIL seq_resp: got keep=%b pc=%h want keep=1 pc=%h", o_resp_keep, o_resp_pc, exp);
            else n_pass++;
            tick();
            rv = 0;
        end
    endtask

    task automatic test_partial_count();
        bit ok;
        go_idle();
        br = 1; ba = 32'h8000_0004;
        tick();
        br = 0; pc_en = 1;
        wait_req(ok);
        n_total++;
        if (!ok || o_req_addr !== 32'h8000_0004)
            $display("FAIL partial_first: got ok=%b addr=%h want 80000004", ok, o_req_addr);
        else n_pass++;
        ready = 1; tick(); ready = 0;
        rv = 1; rc = 2'd1; tick(); rv = 0;
        wait_req(ok);
        n_total++;
        if (!ok || o_req_addr !== 32'h8000_0008)
            $display("FAIL partial_advance: got ok=%b addr=%h want 80000008", ok, o_req_addr);
        else n_pass++;
        ready = 1; tick(); ready = 0;
        rv = 1; rc = 2'd0; tick(); rv = 0;
        wait_req(ok);
        n_total++;
        if (!ok || o_req_addr !== 32'h8000_0008)
            $display("FAIL partial_retry: got ok=%b addr=%h want 80000008", ok, o_req_addr);
        else n_pass++;
    endtask

    task automatic test_flush();
        bit ok;
        go_idle();
        pc_en = 1;
        wait_req(ok);
        ready = 1; tick(); ready = 0;
        br = 1; ba = 32'h8000_0100; tick(); br = 0;
        tick();
        tick();
        rv = 1; rc = 2'd2;
        #1;
        n_total++;
        if (o_resp_keep !== 1'b0) $display("FAIL flush_keep: got %b want 0", o_resp_keep);
        else n_pass++;
        tick();
        rv = 0;
        wait_req(ok);
        n_total++;
        if (!ok || o_req_addr !== 32'h8000_0100)
            $display("FAIL flush_target: got ok=%b addr=%h want 80000100", ok, o_req_addr);
        else n_pass++;
    endtask

    task automatic test_priority();
        bit ok;
        go_idle();
        br = 1; ba = 32'h0000_0100; ex = 1; ea = 32'hbfc0_0380;
        tick();
        br = 0; ex = 0;
        n_total++;
        if (o_pc_address !== 32'hbfc0_0380)
            $display("FAIL prio_same_cycle: got %h want bfc00380", o_pc_address);
        else n_pass++;
        pc_en = 1;
        wait_req(ok);
        ready = 1; tick(); ready = 0; pc_en = 0;
        ex = 1; ea = 32'hbfc0_0400; tick(); ex = 0;
        br = 1; ba = 32'h0000_0100; tick(); br = 0;
        rv = 1; rc = 2'd1;
        #1;
        n_total++;
        if (o_resp_keep !== 1'b0) $display("FAIL prio_flush_keep: got %b want 0", o_resp_keep);
        else n_pass++;
        tick();
        rv = 0;
        n_total++;
        if (o_pc_address !== 32'hbfc0_0400)
            $display("FAIL prio_branch_ignored: got %h want bfc00400", o_pc_address);
        else n_pass++;
    endtask

    task automatic test_stall_retract();
        bit          ok;
        logic [31:0] exp;
        go_idle();
        pc_en = 1;
        exp = m_pc & 32'hffff_fffc;
        wait_req(ok);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (o_req_valid !== 1'b1 || o_req_addr !== exp)
                $display("FAIL stall_stable: got v=%b addr=%h want v=1 addr=%h", o_req_valid, o_req_addr, exp);
            else n_pass++;
        end
        pc_en = 0;
        br = 1; ba = 32'h8000_0200; tick(); br = 0;
        n_total++;
        if (o_req_valid !== 1'b0 || o_pc_address !== 32'h8000_0200)
            $display("FAIL retract: got v=%b pc=%h want v=0 pc=80000200", o_req_valid, o_pc_address);
        else n_pass++;
    endtask

    task automatic test_wrap_adel();
        bit ok;
        go_idle();
        br = 1; ba = 32'hffff_fff8; tick(); br = 0;
        pc_en = 1;
        wait_req(ok);
        n_total++;
        if (!ok || o_req_addr !== 32'hffff_fff8)
            $display("FAIL wrap_req: got ok=%b addr=%h want fffffff8", ok, o_req_addr);
        else n_pass++;
        ready = 1; tick(); ready = 0; pc_en = 0;
        rv = 1; rc = 2'd2; tick(); rv = 0;
        n_total++;
        if (o_pc_address !== 32'h0000_0000)
            $display("FAIL wrap_pc: got %h want 00000000", o_pc_address);
        else n_pass++;
        go_idle();
        br = 1; ba = 32'h8000_0002; tick(); br = 0;
        n_total++;
        if (o_pc_address !== 32'h8000_0002)
            $display("FAIL misalign_pc: got %h want 80000002", o_pc_address);
        else n_pass++;
        pc_en = 1;
`ifdef FETCH_PC_ADEL_EN
        n_total++;
        if (o_fetch_adel !== 1'b1) $display("FAIL adel_set: got %b want 1", o_fetch_adel);
        else n_pass++;
        tick(); tick(); tick();
        n_total++;
        if (o_req_valid !== 1'b0) $display("FAIL adel_no_req: got %b want 0", o_req_valid);
        else n_pass++;
`else
        n_total++;
        if (o_fetch_adel !== 1'b0) $display("FAIL adel_tied: got %b want 0", o_fetch_adel);
        else n_pass++;
        wait_req(ok);
        n_total++;
        if (!ok || o_req_addr !== 32'h8000_0000)
            $display("FAIL align_force: got ok=%b addr=%h want 80000000", ok, o_req_addr);
        else n_pass++;
`endif
        go_idle();
        br = 1; ba = 32'h8000_1000; tick(); br = 0;
        n_total++;
        if (o_fetch_adel !== 1'b0) $display("FAIL adel_clear: got %b want 0", o_fetch_adel);
        else n_pass++;
    endtask

    task automatic test_random();
        int  mx;
        bit  ek;
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 149) == 0);
            pc_en     = ($urandom_range(0, 3) != 0);
            fifo_full = ($urandom_range(0, 4) == 0);
            br        = ($urandom_range(0, 7) == 0);
            ex        = ($urandom_range(0, 15) == 0);
            ba        = $urandom() & 32'hffff_fffc;
            ea        = 32'hbfc0_0000 | ($urandom_range(0, 255) << 2);
            ready     = $urandom_range(0, 1) == 1;
            rv        = m_infl && ($urandom_range(0, 1) == 1);
            mx        = FW - int'((m_raddr >> 2) % FW);
            rc        = CW'($urandom_range(0, mx));
            #1;
            ek = m_infl && m_live && rv && !(br | ex);
            n_total++;
            if (o_req_valid !== m_req || (m_req && o_req_addr !== m_raddr))
                $display("FAIL rnd_req c=%0d: got v=%b a=%h want v=%b a=%h", c, o_req_valid, o_req_addr, m_req, m_raddr);
            else n_pass++;
            n_total++;
            if (o_pc_address !== m_pc)
                $display("FAIL rnd_pc c=%0d: got %h want %h", c, o_pc_address, m_pc);
            else n_pass++;
            n_total++;
            if (o_resp_keep !== ek || (ek && o_resp_pc !== m_pc))
                $display("FAIL rnd_keep c=%0d: got k=%b pc=%h want k=%b pc=%h", c, o_resp_keep, o_resp_pc, ek, m_pc);
            else n_pass++;
            n_total++;
            if (o_fetch_adel !== m_adel)
                $display("FAIL rnd_adel c=%0d: got %b want %b", c, o_fetch_adel, m_adel);
            else n_pass++;
            tick();
        end
        rst = 0;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_partial_count();
        test_flush();
        test_priority();
        test_stall_retract();
        test_wrap_adel();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
